// File: rtl/gb_line_doubler.sv
// Ping-pong line buffer that captures 160-pixel Game Boy scanlines and replays each one
// as a valid/ready stream, repeated H_SCALE times per pixel and V_SCALE times per line.
module gb_line_doubler #(
   parameter int unsigned LINE_W  = 160,
   parameter int unsigned H_SCALE = 2,
   parameter int unsigned V_SCALE = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] pixel_data,
   input  logic [7:0] pixel_count,
   input  logic [7:0] line_count,
   input  logic       pixel_we,
   output logic [1:0] out_pixel,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sol,
   output logic       out_eol,
   output logic       out_sof,
   output logic [7:0] out_line,
   output logic       overflow,
   output logic [7:0] drop_cnt
);

   localparam logic [7:0] LastPix = 8'(LINE_W - 1);
   localparam logic [1:0] HLast   = 2'(H_SCALE - 1);
   localparam logic [1:0] VLast   = 2'(V_SCALE - 1);

   typedef enum logic [0:0] {StIdle, StEmit} state_e;

   state_e     state_q, state_d;
   logic [1:0] full_q, full_d;
   logic [7:0] line_q [0:1];
   logic       wr_bank_q;
   logic       rd_bank_q, rd_bank_d;
   logic       active_q;
   logic [7:0] x_q, x_d;
   logic [1:0] rh_q, rh_d;
   logic [1:0] rv_q, rv_d;
   logic       vld_q, vld_d;
   logic       overflow_q;
   logic [7:0] drop_cnt_q;
   logic [1:0] pix_q;
   logic [1:0] mem [0:1][0:LINE_W-1];

   logic in_range, start, wr_full, do_write, complete, drop, release_bank;

   // Read side: counters always describe the beat currently presented (or about to be).
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      rh_d         = rh_q;
      rv_d         = rv_q;
      vld_d        = vld_q;
      rd_bank_d    = rd_bank_q;
      release_bank = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (full_q[rd_bank_q]) begin
               state_d = StEmit;
               x_d     = 8'd0;
               rh_d    = 2'd0;
               rv_d    = 2'd0;
            end
         end
         StEmit: begin
            if (!vld_q) begin
               vld_d = 1'b1;
            end else if (out_ready) begin
               if (rh_q != HLast) begin
                  rh_d = rh_q + 2'd1;
               end else begin
                  rh_d = 2'd0;
                  if (x_q != LastPix) begin
                     x_d = x_q + 8'd1;
                  end else begin
                     x_d = 8'd0;
                     if (rv_q != VLast) begin
                        rv_d = rv_q + 2'd1;
                     end else begin
                        rv_d         = 2'd0;
                        release_bank = 1'b1;
                        rd_bank_d    = ~rd_bank_q;
                        if (!full_q[~rd_bank_q]) begin
                           state_d = StIdle;
                           vld_d   = 1'b0;
                        end
                     end
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A bank released this cycle is already free for a new line start.
   always_comb begin
      in_range = pixel_we && (pixel_count <= LastPix);
      start    = in_range && (pixel_count == 8'd0);
      wr_full  = full_q[wr_bank_q] && !(release_bank && (rd_bank_q == wr_bank_q));
      do_write = in_range && (start ? !wr_full : active_q);
      complete = do_write && (pixel_count == LastPix);
      drop     = start && wr_full;
   end

   always_comb begin
      full_d = full_q;
      if (release_bank) full_d[rd_bank_q] = 1'b0;
      if (complete)     full_d[wr_bank_q] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         full_q     <= 2'b00;
         line_q[0]  <= 8'd0;
         line_q[1]  <= 8'd0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         active_q   <= 1'b0;
         x_q        <= 8'd0;
         rh_q       <= 2'd0;
         rv_q       <= 2'd0;
         vld_q      <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         full_q    <= full_d;
         rd_bank_q <= rd_bank_d;
         x_q       <= x_d;
         rh_q      <= rh_d;
         rv_q      <= rv_d;
         vld_q     <= vld_d;
         wr_bank_q <= wr_bank_q ^ complete;
         if (start) begin
            active_q <= !wr_full;
         end else if (complete) begin
            active_q <= 1'b0;
         end
         if (complete) line_q[wr_bank_q] <= line_count;
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 8'hff) drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   // Read address follows the next-state beat, so a stalled beat re-reads the same word.
   always_ff @(posedge clock) begin
      if (do_write) mem[wr_bank_q][pixel_count] <= pixel_data;
      pix_q <= mem[rd_bank_d][x_d];
   end

   assign out_valid = vld_q;
   assign out_pixel = vld_q ? pix_q : 2'd0;
   assign out_line  = vld_q ? line_q[rd_bank_q] : 8'd0;
   assign out_sol   = vld_q && (x_q == 8'd0) && (rh_q == 2'd0);
   assign out_eol   = vld_q && (x_q == LastPix) && (rh_q == HLast);
   assign out_sof   = out_sol && (rv_q == 2'd0) && (line_q[rd_bank_q] == 8'd0);
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gb_line_doubler.sv
// Directed bench for gb_line_doubler: default 2x2 instance plus a 1x1 instance.
module tb_gb_line_doubler;

   logic       clock;
   logic       reset;
   logic [1:0] pixel_data;
   logic [7:0] pixel_count;
   logic [7:0] line_count;
   logic       pixel_we;
   logic       out_ready;
   logic [1:0] out_pixel;
   logic       out_valid, out_sol, out_eol, out_sof, overflow;
   logic [7:0] out_line, drop_cnt;

   logic [1:0] s_pixel_data;
   logic [7:0] s_pixel_count;
   logic [7:0] s_line_count;
   logic       s_pixel_we;
   logic       s_out_ready;
   logic [1:0] s_out_pixel;
   logic       s_out_valid, s_out_sol, s_out_eol, s_out_sof, s_overflow;
   logic [7:0] s_out_line, s_drop_cnt;

   int checks;
   int errors;

   gb_line_doubler dut (
      .clock      (clock),
      .reset      (reset),
      .pixel_data (pixel_data),
      .pixel_count(pixel_count),
      .line_count (line_count),
      .pixel_we   (pixel_we),
      .out_pixel  (out_pixel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sol    (out_sol),
      .out_eol    (out_eol),
      .out_sof    (out_sof),
      .out_line   (out_line),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt)
   );

   gb_line_doubler #(.LINE_W(160), .H_SCALE(1), .V_SCALE(1)) dut_s (
      .clock      (clock),
      .reset      (reset),
      .pixel_data (s_pixel_data),
      .pixel_count(s_pixel_count),
      .line_count (s_line_count),
      .pixel_we   (s_pixel_we),
      .out_pixel  (s_out_pixel),
      .out_valid  (s_out_valid),
      .out_ready  (s_out_ready),
      .out_sol    (s_out_sol),
      .out_eol    (s_out_eol),
      .out_sof    (s_out_sof),
      .out_line   (s_out_line),
      .overflow   (s_overflow),
      .drop_cnt   (s_drop_cnt)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write_line(input logic [7:0] ln);
      for (int x = 0; x < 160; x++) begin
         pixel_we    = 1'b1;
         pixel_count = 8'(x);
         pixel_data  = 2'((x + int'(ln)) % 4);
         line_count  = ln;
         step();
      end
      pixel_we = 1'b0;
   endtask

   // Consume one 640-beat replay of line ln, checking every beat and stall stability.
   task automatic collect(input logic [7:0] ln, input bit toggle);
      int b;
      int cyc;
      int hb;
      bit stalled;
      logic [13:0] prev;
      logic [13:0] now;
      logic [12:0] exp_v;
      b = 0;
      cyc = 0;
      stalled = 1'b0;
      prev = '0;
      while (b < 640 && cyc < 4000) begin
         out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
         now = {out_valid, out_pixel, out_sol, out_eol, out_sof, out_line};
         if (stalled) begin
            checks++;
            if (now !== prev) begin
               errors++;
               $display("FAIL stall_hold line %0d beat %0d: got %h want %h", ln, b, now, prev);
            end
         end
         stalled = 1'b0;
         if (out_valid === 1'b1) begin
            hb = b % 320;
            exp_v = {2'((hb / 2 + int'(ln)) % 4), hb == 0, hb == 319, (b == 0) && (ln == 8'd0), ln};
            checks++;
            if (now[12:0] !== exp_v) begin
               errors++;
               $display("FAIL beat line %0d beat %0d: got %h want %h", ln, b, now[12:0], exp_v);
            end
            if (out_ready) b++;
            else begin
               stalled = 1'b1;
               prev = now;
            end
         end
         step();
         cyc++;
      end
      checks++;
      if (b != 640) begin
         errors++;
         $display("FAIL beat_count line %0d: got %0d want 640", ln, b);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      checks++;
      if ({out_valid, out_pixel, out_sol, out_eol, out_sof, out_line, overflow, drop_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b ovf=%b drop=%0d want 0", out_valid, overflow,
                  drop_cnt);
      end
      reset = 1'b0;
      repeat (2) step();
      checks++;
      if ({out_valid, s_out_valid, overflow, drop_cnt} !== '0) begin
         errors++;
         $display("FAIL post_reset_idle: got valid=%b s_valid=%b ovf=%b drop=%0d want 0",
                  out_valid, s_out_valid, overflow, drop_cnt);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      write_line(8'd0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_e0: got valid=%b want 0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_e1: got valid=%b want 0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL latency_e2: got valid=%b want 1", out_valid);
      end
      collect(8'd0, 1'b0);
      repeat (3) step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: got valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      write_line(8'd0);
      collect(8'd0, 1'b1);
      out_ready = 1'b1;
      repeat (3) step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_done: got valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      write_line(8'd5);
      write_line(8'd6);
      write_line(8'd7);
      repeat (3) step();
      checks++;
      if ({overflow, drop_cnt} !== {1'b1, 8'd1}) begin
         errors++;
         $display("FAIL drop_flags: got ovf=%b drop=%0d want ovf=1 drop=1", overflow, drop_cnt);
      end
      checks++;
      if ({out_valid, out_line} !== {1'b1, 8'd5}) begin
         errors++;
         $display("FAIL held_line5: got valid=%b line=%0d want valid=1 line=5", out_valid, out_line);
      end
      collect(8'd5, 1'b0);
      checks++;
      if ({out_valid, out_line} !== {1'b1, 8'd6}) begin
         errors++;
         $display("FAIL zero_bubble: got valid=%b line=%0d want valid=1 line=6", out_valid, out_line);
      end
      collect(8'd6, 1'b0);
      repeat (5) step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL line7_dropped: got valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_out_of_range();
      out_ready = 1'b1;
      for (int pc = 160; pc <= 200; pc++) begin
         pixel_we    = 1'b1;
         pixel_count = 8'(pc);
         pixel_data  = 2'd3;
         line_count  = 8'd1;
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL out_of_range_valid pc %0d: got %b want 0", pc, out_valid);
         end
      end
      pixel_we = 1'b0;
      repeat (5) step();
      checks++;
      if ({out_valid, overflow, drop_cnt} !== {1'b0, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL out_of_range_state: got valid=%b ovf=%b drop=%0d want 0/1/1", out_valid,
                  overflow, drop_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int b;
      int cyc;
      out_ready = 1'b1;
      write_line(8'd0);
      b = 0;
      cyc = 0;
      while (b < 100 && cyc < 500) begin
         if (out_valid === 1'b1) b++;
         step();
         cyc++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_replay_reached: got valid=%b after %0d beats want 1", out_valid, b);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_pixel, out_sol, out_eol, out_sof, out_line, overflow, drop_cnt} !== '0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b line=%0d ovf=%b drop=%0d want 0", out_valid,
                  out_line, overflow, drop_cnt);
      end
      step();
      step();
      reset = 1'b0;
      repeat (10) step();
      checks++;
      if ({out_valid, overflow, drop_cnt} !== '0) begin
         errors++;
         $display("FAIL after_reset: got valid=%b ovf=%b drop=%0d want 0", out_valid, overflow,
                  drop_cnt);
      end
      for (int x = 100; x < 160; x++) begin
         pixel_we    = 1'b1;
         pixel_count = 8'(x);
         pixel_data  = 2'd1;
         line_count  = 8'd9;
         step();
      end
      pixel_we = 1'b0;
      repeat (5) step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL partial_line: got valid=%b want 0", out_valid);
      end
      write_line(8'd2);
      collect(8'd2, 1'b0);
   endtask

   task automatic test_scale1();
      int b;
      int nsol;
      int neol;
      int nsof;
      logic [11:0] exp_v;
      s_out_ready = 1'b1;
      for (int x = 0; x < 160; x++) begin
         s_pixel_we    = 1'b1;
         s_pixel_count = 8'(x);
         s_pixel_data  = 2'((x + 3) % 4);
         s_line_count  = 8'd3;
         step();
      end
      s_pixel_we = 1'b0;
      b = 0;
      nsol = 0;
      neol = 0;
      nsof = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (s_out_valid === 1'b1) begin
            exp_v = {2'((b + 3) % 4), b == 0, b == 159, 8'd3};
            checks++;
            if ({s_out_pixel, s_out_sol, s_out_eol, s_out_line} !== exp_v) begin
               errors++;
               $display("FAIL scale1_beat %0d: got %h want %h", b, {s_out_pixel, s_out_sol,
                        s_out_eol, s_out_line}, exp_v);
            end
            if (s_out_sol) nsol++;
            if (s_out_eol) neol++;
            if (s_out_sof) nsof++;
            b++;
         end
         step();
      end
      checks++;
      if (b != 160) begin
         errors++;
         $display("FAIL scale1_count: got %0d want 160", b);
      end
      checks++;
      if (nsol != 1 || neol != 1 || nsof != 0) begin
         errors++;
         $display("FAIL scale1_flags: got sol=%0d eol=%0d sof=%0d want 1/1/0", nsol, neol, nsof);
      end
   endtask

   initial begin
      clock         = 1'b0;
      reset         = 1'b1;
      pixel_data    = 2'd0;
      pixel_count   = 8'd0;
      line_count    = 8'd0;
      pixel_we      = 1'b0;
      out_ready     = 1'b0;
      s_pixel_data  = 2'd0;
      s_pixel_count = 8'd0;
      s_line_count  = 8'd0;
      s_pixel_we    = 1'b0;
      s_out_ready   = 1'b1;
      checks        = 0;
      errors        = 0;
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid();
      test_scale1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gb_line_doubler.md
Name: gb_line_doubler

Overview:
- Sits between the video module's pixel-write stream (2-bit pixel, pixel index, line index, write strobe) and the display-side consumer in the GPU.
- Captures each 160-pixel Game Boy scanline into a ping-pong line buffer.
- Replays each line as a valid/ready stream scaled H_SCALE x horizontally and V_SCALE x vertically, so a 160x144 frame becomes 320x288 at the default scale.
- Decouples the bursty pixel-write timing of the PPU from the steady consumption of the output stage.

Parameters:
- LINE_W, 160, pixels per GB scanline; pixel indices 0..LINE_W-1.
- H_SCALE, 2, output beats per stored pixel (1..4).
- V_SCALE, 2, output repetitions per stored line (1..4).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pixel_data  in  2  GB shade index being written.
- pixel_count  in  8  pixel index of pixel_data.
- line_count  in  8  scanline index of the current write.
- pixel_we  in  1  write strobe; one pixel per cycle when high.
- out_pixel  out  2  scaled pixel.
- out_valid  out  1  out_pixel is valid.
- out_ready  in  1  consumer accepts the beat when valid & ready.
- out_sol  out  1  first beat of an output line.
- out_eol  out  1  last beat of an output line.
- out_sof  out  1  first beat of the frame: source line 0, first vertical repeat.
- out_line  out  8  source line_count of the line being replayed.
- overflow  out  1  sticky: a source line was dropped. Cleared only by reset.
- drop_cnt  out  8  count of dropped lines; saturates at 255.

Behaviour:

Storage and reset
- Two banks of LINE_W x 2 bits.
- Per bank: full flag and captured line_count.
- Pointers: wr_bank, rd_bank.
- Reset (async, high): full flags=0, wr_bank=rd_bank=0, FSM=IDLE, all outputs 0, overflow=0, drop_cnt=0. RAM contents are not cleared.
- Reset asserted mid-line or mid-replay abandons both lines; no partial beats appear after deassertion.

Write side
- When pixel_we=1 and pixel_count<LINE_W, pixel_data is written to bank[wr_bank][pixel_count].
- pixel_we with pixel_count>=LINE_W is ignored.
- On the write of pixel_count==LINE_W-1:
  - full[wr_bank] is set.
  - line_count is latched for that bank.
  - wr_bank toggles.
- Drop rule: if full[wr_bank]=1 when a write with pixel_count==0 arrives, the whole line is discarded.
  - No RAM writes occur for that line.
  - The bank is not marked.
  - overflow is set and drop_cnt increments once.
- A line is never half-overwritten.

Read side FSM
- States: IDLE, EMIT.
- IDLE:
  - If full[rd_bank], load x=0, rh=0, rv=0 and go to EMIT.
  - out_valid asserts exactly 2 cycles after the clock edge that sampled the completing write. This covers one cycle for the full-flag update and one for the synchronous RAM read.
- EMIT: out_valid=1.
  - out_pixel = bank[rd_bank][x].
  - out_line = latched line_count for rd_bank.
  - out_pixel, out_sol, out_eol, out_sof and out_line are held stable while out_valid & !out_ready.
- On each accepted beat, rh increments.
  - At rh==H_SCALE-1: rh=0, x increments.
  - At x==LINE_W-1 with rh last: x=0, rv increments.
  - At rv==V_SCALE-1: clear full[rd_bank], toggle rd_bank.
  - If the other bank is already full, continue in EMIT with zero bubble (the next beat is valid on the following cycle). Otherwise go to IDLE.
- Flag timing:
  - out_sol=1 on beat x=0, rh=0.
  - out_eol=1 on beat x=LINE_W-1, rh=H_SCALE-1.
  - out_sof=1 on beat x=0, rh=0, rv=0 when the latched line is 0.
- Each source line yields LINE_W*H_SCALE*V_SCALE beats (640 at defaults).

Simultaneous events
- A completing write to one bank and a read releasing the other bank in the same cycle both take effect.
- A write targeting the bank being released in that same cycle sees it as not full, so no drop occurs.

Test Plan:
1. Reset, write line 0 (pixels 0..159, data=x%4), out_ready=1 -> out_valid rises 2 cycles after the pixel-159 write. Output is 640 beats: pixel values 0,0,1,1,2,2,3,3,... per 320-beat line, repeated twice. out_sof on beat 0 only; out_sol on beats 0 and 320; out_eol on beats 319 and 639.
2. Same stimulus with out_ready toggling every cycle -> identical 640-beat sequence; outputs held stable during stalls; no beats lost or duplicated.
3. out_ready=0, write lines 5, 6, 7 back-to-back -> lines 5 and 6 stored; line 7 dropped; overflow=1, drop_cnt=1. After releasing ready, out_line reads 5 (640 beats) then 6 with zero bubble between them.
4. Write pixel_count 160..200 with pixel_we=1 -> no RAM change, no full flag set, out_valid stays 0.
5. Assert reset during beat 100 of a replay -> all outputs 0 immediately. After deassertion out_valid stays 0 until a new full line is written; overflow and drop_cnt are 0.
6. H_SCALE=1, V_SCALE=1 build, write line 3 -> exactly 160 beats, out_line=3, out_sol and out_eol each asserted once, out_sof never asserted.
